// File: rtl/spi_master_clkgen.sv
// SPI clock generator: divides clk by 2*(target+1) into a 50%-duty spi_clk,
// with one-cycle look-ahead strobes for the rising and falling spi_clk edges.
module spi_master_clkgen (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] clk_div,
    input  logic       clk_div_valid,
    output logic       spi_clk,
    output logic       spi_rise,
    output logic       spi_fall
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             spi_clk_q, spi_clk_d;
    logic             terminal;
    logic             active;

    // >= rather than == so a target shrunk below the running count ends the
    // current half-period on the next edge instead of wrapping the counter.
    assign terminal = (counter_q >= target_q);
    assign active   = en | spi_clk_q;

    always_comb begin
        target_d  = clk_div_valid ? clk_div : target_q;
        counter_d = counter_q;
        spi_clk_d = spi_clk_q;
        if (active) begin
            if (terminal) begin
                counter_d = '0;
                spi_clk_d = ~spi_clk_q;
            end else begin
                counter_d = counter_q + 1'b1;
            end
        end else begin
            counter_d = '0;
            spi_clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target_q  <= '0;
            counter_q <= '0;
            spi_clk_q <= 1'b0;
        end else begin
            target_q  <= target_d;
            counter_q <= counter_d;
            spi_clk_q <= spi_clk_d;
        end
    end

    // Strobes are gated by rstn so they stay quiet while reset is held.
    assign spi_clk  = spi_clk_q;
    assign spi_rise = rstn & en & ~spi_clk_q & terminal;
    assign spi_fall = rstn & spi_clk_q & terminal;

endmodule

// File: tb/tb_spi_master_clkgen.sv
// Randomized and directed bench for spi_master_clkgen against a half-period
// reference model.
module tb_spi_master_clkgen;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [7:0] clk_div;
    logic       clk_div_valid;
    logic       spi_clk;
    logic       spi_rise;
    logic       spi_fall;

    int checks = 0;
    int errors = 0;

    // Reference model: level of spi_clk, cycles already spent in the current
    // half-period, and the half-period length minus one.
    logic m_clk = 1'b0;
    int   m_elapsed = 0;
    int   m_len = 0;

    logic s_clk, s_rise, s_fall;
    logic prev_clk = 1'b0;
    int   run_len = 0;
    int   last_hi = 0;
    int   last_lo = 0;
    int   run_done = 0;

    spi_master_clkgen dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .clk_div      (clk_div),
        .clk_div_valid(clk_div_valid),
        .spi_clk      (spi_clk),
        .spi_rise     (spi_rise),
        .spi_fall     (spi_fall)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        logic half_done, e_rise, e_fall;
        @(negedge clk);
        half_done = (m_elapsed >= m_len);
        e_rise = en && !m_clk && half_done;
        e_fall = m_clk && half_done;
        s_clk = spi_clk;
        s_rise = spi_rise;
        s_fall = spi_fall;
        checks++;
        if (s_clk !== m_clk) begin
            errors++;
            $display("FAIL spi_clk @%0t: got %b expected %b", $time, s_clk, m_clk);
        end
        checks++;
        if (s_rise !== e_rise) begin
            errors++;
            $display("FAIL spi_rise @%0t: got %b expected %b", $time, s_rise, e_rise);
        end
        checks++;
        if (s_fall !== e_fall) begin
            errors++;
            $display("FAIL spi_fall @%0t: got %b expected %b", $time, s_fall, e_fall);
        end
        if (s_clk === prev_clk) begin
            run_len++;
        end else begin
            if (prev_clk) last_hi = run_len;
            else last_lo = run_len;
            run_done++;
            run_len = 1;
            prev_clk = s_clk;
        end
        @(posedge clk);
        if (en || m_clk) begin
            if (half_done) begin
                m_clk = !m_clk;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else begin
            m_clk = 1'b0;
            m_elapsed = 0;
        end
        if (clk_div_valid) m_len = clk_div;
        #1;
    endtask

    task automatic go_idle();
        en = 1'b0;
        clk_div_valid = 1'b0;
        for (int i = 0; i < 600 && m_clk; i++) cycle();
        cycle();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en = 1'b1;
        clk_div = 8'd5;
        clk_div_valid = 1'b1;
        #12;
        checks++;
        if (spi_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_spi_clk: got %b expected 0", spi_clk);
        end
        checks++;
        if (spi_rise !== 1'b0) begin
            errors++;
            $display("FAIL reset_spi_rise: got %b expected 0", spi_rise);
        end
        checks++;
        if (spi_fall !== 1'b0) begin
            errors++;
            $display("FAIL reset_spi_fall: got %b expected 0", spi_fall);
        end
        en = 1'b0;
        clk_div_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_div0();
        en = 1'b1;
        clk_div = 8'd0;
        clk_div_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ((s_rise ^ s_fall) !== 1'b1) begin
                errors++;
                $display("FAIL div0_alternate: rise %b fall %b expected exactly one", s_rise, s_fall);
            end
        end
    endtask

    task automatic test_div1();
        clk_div = 8'd1;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (last_hi !== 2 || last_lo !== 2) begin
            errors++;
            $display("FAIL div1_period: hi %0d lo %0d expected 2 and 2", last_hi, last_lo);
        end
    endtask

    task automatic test_change();
        int start;
        cycle();
        clk_div = 8'd3;
        start = run_done;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (run_done != start && s_clk !== prev_clk) begin
                checks++;
                errors++;
                $display("FAIL change_track: inconsistent sample");
            end
        end
        checks++;
        if (last_hi < 2 || last_lo < 2) begin
            errors++;
            $display("FAIL change_min_half: hi %0d lo %0d expected >= 2", last_hi, last_lo);
        end
        checks++;
        if (last_hi !== 4 || last_lo !== 4) begin
            errors++;
            $display("FAIL change_period: hi %0d lo %0d expected 4 and 4", last_hi, last_lo);
        end
    endtask

    task automatic test_en_drop();
        int hi, falls, rises;
        bit found;
        go_idle();
        clk_div = 8'd2;
        clk_div_valid = 1'b1;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (spi_clk === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL en_drop_rise: got no rise within 20 cycles, expected one");
        end
        hi = 0;
        falls = 0;
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (i == 0) en = 1'b0;
            hi += int'(s_clk);
            falls += int'(s_fall);
            rises += int'(s_rise);
        end
        checks++;
        if (hi !== 3) begin
            errors++;
            $display("FAIL en_drop_high: got %0d cycles expected 3", hi);
        end
        checks++;
        if (falls !== 1 || rises !== 0) begin
            errors++;
            $display("FAIL en_drop_strobes: falls %0d rises %0d expected 1 and 0", falls, rises);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clk_div = 8'd4;
        clk_div_valid = 1'b1;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (spi_clk === 1'b1) found = 1;
        end
        cycle();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (spi_clk !== 1'b0 || spi_fall !== 1'b0 || spi_rise !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: clk %b rise %b fall %b expected 0 0 0", spi_clk, spi_rise, spi_fall);
        end
        m_clk = 1'b0;
        m_elapsed = 0;
        m_len = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        clk_div = 8'd0;
        clk_div_valid = 1'b1;
        en = 1'b1;
        rstn = 1'b1;
        cycle();
        checks++;
        if (s_rise !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_rise: got %b expected 1", s_rise);
        end
        for (int i = 0; i < 6; i++) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            clk_div = 8'($urandom_range(0, 6));
            clk_div_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) clk_div = 8'($urandom);
            cycle();
        end
    endtask

    task automatic test_div255();
        go_idle();
        clk_div = 8'd255;
        clk_div_valid = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 1100; i++) cycle();
        checks++;
        if (last_hi !== 256) begin
            errors++;
            $display("FAIL div255_high: got %0d cycles expected 256", last_hi);
        end
        checks++;
        if (last_lo !== 256) begin
            errors++;
            $display("FAIL div255_low: got %0d cycles expected 256", last_lo);
        end
    endtask

    initial begin
        test_reset();
        test_div0();
        test_div1();
        test_change();
        test_en_drop();
        test_reset_mid();
        test_random();
        test_div255();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_clkgen.md
SPI_MASTER_CLKGEN -- requirements
Module: spi_master_clkgen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 Port en, input, 1 bit: generator enable.
REQ-005 Port clk_div, input, 8 bits: divider value; half-period of spi_clk is clk_div+1 clk cycles.
REQ-006 Port clk_div_valid, input, 1 bit: load strobe for clk_div; level-sensitive, may be held high.
REQ-007 Port spi_clk, output, 1 bit: generated SPI clock, registered.
REQ-008 Port spi_rise, output, 1 bit: combinational strobe, high in the clk cycle after which spi_clk goes 0->1.
REQ-009 Port spi_fall, output, 1 bit: combinational strobe, high in the clk cycle after which spi_clk goes 1->0.

Function
REQ-010 The block SHALL hold an 8-bit target register and an 8-bit counter.
REQ-011 When clk_div_valid=1 at a clk edge, the target register SHALL take clk_div; the counter is not cleared by the load.
REQ-012 Terminal condition: counter >= target (unsigned 8-bit compare); the >= form covers a shrink of target mid-count.
REQ-013 Active state: en=1 or spi_clk=1.
REQ-014 In the active state: terminal -> counter cleared to 0 at the next edge and spi_clk toggled; otherwise counter incremented by 1.
REQ-015 Inactive state (en=0 and spi_clk=0): counter held at 0, spi_clk held at 0, both strobes 0.
REQ-016 spi_rise SHALL equal en AND NOT spi_clk AND terminal.
REQ-017 spi_fall SHALL equal spi_clk AND terminal.
REQ-018 Strobes SHALL be single-cycle and never both high in the same cycle.
REQ-019 Steady-state spi_clk period SHALL be 2*(target+1) clk cycles with 50% duty.
- target=0 toggles every cycle.
- target=255 gives a 512-cycle period.
REQ-020 From idle (counter 0, spi_clk 0), en asserted: spi_rise SHALL be high in the (target+1)-th cycle of en; spi_clk SHALL be high one edge later.
REQ-021 en deasserted while spi_clk=0: no further rise; the clock stays low.
REQ-022 en deasserted while spi_clk=1: the high phase SHALL complete its full length, spi_fall SHALL pulse, and the block then goes idle.
REQ-023 A target change SHALL take effect on the half-period in progress; no glitch or partial toggle is allowed.
REQ-024 The counter SHALL never wrap: it clears at terminal and terminal is reached no later than count 255.

Reset
REQ-025 While rstn=0, the block SHALL force spi_clk=0, counter=0, and target=0 immediately, independent of clk.
REQ-026 The strobes SHALL be 0 during reset.
REQ-027 After rstn deasserts, operation SHALL start from idle; a reset mid-operation SHALL drop spi_clk low at once, with no spi_fall pulse.

Structure
REQ-028 The block SHALL be a single module with no sub-modules.
REQ-029 No shared package is required.
REQ-030 Counter and target width SHALL be a local constant of 8 matching clk_div.

Verification
REQ-031 Reset, then en=1, clk_div=0 with clk_div_valid=1 held -> spi_clk toggles every clk cycle; spi_rise and spi_fall alternate each cycle.
REQ-032 clk_div=1 loaded -> spi_clk period 4 clk cycles; each strobe once per 4 cycles, one cycle before the matching edge.
REQ-033 clk_div=3 loaded while running at clk_div=1 -> period 8 cycles from the next toggle; no half-period shorter than 2 cycles.
REQ-034 clk_div=2, en dropped one cycle after spi_clk rises -> spi_clk stays high 3 cycles total, spi_fall pulses once, then spi_clk=0, counter=0, no further strobes.
REQ-035 rstn pulsed low mid high-phase -> spi_clk=0 immediately; after release with en=1, clk_div=0, the first spi_rise appears in the first cycle.
REQ-036 clk_div=255 -> spi_clk high 256 cycles and low 256 cycles; the counter never exceeds 255.
